// File: rtl/game_pkg.sv
// Shared command, phase and status-tag definitions for the game-phase controller.
`timescale 1ns/1ps
package game_pkg;

   localparam logic [2:0] FUNC_NOP    = 3'b000;
   localparam logic [2:0] FUNC_START  = 3'b001;
   localparam logic [2:0] FUNC_END    = 3'b010;
   localparam logic [2:0] FUNC_PAUSE  = 3'b011;
   localparam logic [2:0] FUNC_RESUME = 3'b100;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'b00,
      PH_RUN   = 2'b01,
      PH_STOP  = 2'b10,
      PH_PAUSE = 2'b11
   } phase_t;

   localparam logic [1:0] STATUS_TAG = 2'b01;

endpackage

// File: rtl/game_state_ctrl_round_timer.sv
// Round countdown: loads a fixed tick count, decrements on dec_en, pulses expire on 1->0.
`timescale 1ns/1ps
module round_timer #(
   parameter int unsigned TIMER_W  = 16,
   parameter int unsigned LOAD_VAL = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               dec_en,
   output logic [TIMER_W-1:0] count,
   output logic               expire
);

   localparam logic [TIMER_W-1:0] LOAD_CNT = TIMER_W'(LOAD_VAL);
   localparam logic [TIMER_W-1:0] ONE_CNT  = TIMER_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         expire <= 1'b0;
      end else begin
         expire <= 1'b0;
         if (load) begin
            count <= LOAD_CNT;
         end else if (dec_en && (count != '0)) begin
            count  <= count - ONE_CNT;
            expire <= (count == ONE_CNT);
         end
      end
   end

endmodule

// File: rtl/game_state_ctrl.sv
// Game-phase controller: command FSM, latched mode, round timer and packed status word.
`timescale 1ns/1ps
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int unsigned STATE_W     = 8,
   parameter int unsigned MODE_W      = 2,
   parameter int unsigned TIMER_W     = 16,
   parameter int unsigned ROUND_TICKS = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [2:0]         func,
   input  logic [MODE_W-1:0]  mode_sel,
   input  logic               tick,
   output logic [STATE_W-1:0] game_state,
   output logic [TIMER_W-1:0] time_left,
   output logic               running,
   output logic               done,
   output logic               cmd_err
);

   localparam bit TIMED = (ROUND_TICKS != 0);

   phase_t            phase_q, phase_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic              cmd_err_q, cmd_err_d;
   logic              load, cmd_take, dec_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q   <= PH_IDLE;
         mode_q    <= '0;
         cmd_err_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         mode_q    <= mode_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   always_comb begin
      phase_d   = phase_q;
      mode_d    = mode_q;
      cmd_err_d = 1'b0;
      load      = 1'b0;
      cmd_take  = 1'b0;
      if (en) begin
         case (func)
            FUNC_NOP: ;
            FUNC_START: begin
               if ((phase_q == PH_IDLE) || (phase_q == PH_STOP)) begin
                  phase_d  = PH_RUN;
                  mode_d   = mode_sel;
                  load     = 1'b1;
                  cmd_take = 1'b1;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            FUNC_END: begin
               if ((phase_q == PH_RUN) || (phase_q == PH_PAUSE)) begin
                  phase_d  = PH_STOP;
                  cmd_take = 1'b1;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            FUNC_PAUSE: begin
               if (phase_q == PH_RUN) begin
                  phase_d  = PH_PAUSE;
                  cmd_take = 1'b1;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            FUNC_RESUME: begin
               if (phase_q == PH_PAUSE) begin
                  phase_d  = PH_RUN;
                  cmd_take = 1'b1;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            default: cmd_err_d = 1'b1;
         endcase
      end

      // Accepted commands win over the tick; rejected ones and NOPs do not block it.
      dec_en = tick && (phase_q == PH_RUN) && TIMED && !cmd_take;
      if (dec_en && (time_left == TIMER_W'(1))) begin
         phase_d = PH_STOP;
      end
   end

   round_timer #(
      .TIMER_W  (TIMER_W),
      .LOAD_VAL (ROUND_TICKS)
   ) u_round_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .dec_en (dec_en),
      .count  (time_left),
      .expire (done)
   );

   always_comb begin
      game_state               = '0;
      game_state[1:0]          = STATUS_TAG;
      game_state[3:2]          = phase_q;
      game_state[4 +: MODE_W]  = mode_q;
   end

   assign running = (phase_q == PH_RUN);
   assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomised and directed checks of game_state_ctrl against a behavioural phase model.
`timescale 1ns/1ps
module tb_game_state_ctrl;

   localparam int RT = 60;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, tick = 1'b0;
   logic [2:0]  func = 3'b000;
   logic [1:0]  mode_sel = 2'b00;
   logic [7:0]  game_state;
   logic [15:0] time_left;
   logic        running, done, cmd_err;

   logic        en0 = 1'b0, tick0 = 1'b0;
   logic [2:0]  func0 = 3'b000;
   logic [1:0]  mode_sel0 = 2'b00;
   logic [7:0]  game_state0;
   logic [15:0] time_left0;
   logic        running0, done0, cmd_err0;

   int checks = 0;
   int passes = 0;

   // Model: phase 0 idle, 1 run, 2 stop, 3 pause
   int m_phase, m_mode, m_time;
   bit m_done, m_err;

   always #5 clk = ~clk;

   game_state_ctrl #(.STATE_W(8), .MODE_W(2), .TIMER_W(16), .ROUND_TICKS(RT)) dut (
      .clk(clk), .rst(rst), .en(en), .func(func), .mode_sel(mode_sel), .tick(tick),
      .game_state(game_state), .time_left(time_left), .running(running), .done(done),
      .cmd_err(cmd_err)
   );

   game_state_ctrl #(.STATE_W(8), .MODE_W(2), .TIMER_W(16), .ROUND_TICKS(0)) dut0 (
      .clk(clk), .rst(rst), .en(en0), .func(func0), .mode_sel(mode_sel0), .tick(tick0),
      .game_state(game_state0), .time_left(time_left0), .running(running0), .done(done0),
      .cmd_err(cmd_err0)
   );

   function automatic logic [7:0] exp_gs();
      return 8'(m_mode * 16 + m_phase * 4 + 1);
   endfunction

   task automatic model_reset();
      m_phase = 0; m_mode = 0; m_time = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step(input bit e, input int f, input int ms, input bit t);
      bit took;
      took = 0; m_done = 0; m_err = 0;
      if (e) begin
         if (f == 1) begin
            if (m_phase == 0 || m_phase == 2) begin
               m_phase = 1; m_mode = ms; m_time = RT; took = 1;
            end else m_err = 1;
         end else if (f == 2) begin
            if (m_phase == 1 || m_phase == 3) begin m_phase = 2; took = 1; end
            else m_err = 1;
         end else if (f == 3) begin
            if (m_phase == 1) begin m_phase = 3; took = 1; end else m_err = 1;
         end else if (f == 4) begin
            if (m_phase == 3) begin m_phase = 1; took = 1; end else m_err = 1;
         end else if (f != 0) begin
            m_err = 1;
         end
      end
      if (!took && t && m_phase == 1 && RT != 0 && m_time > 0) begin
         m_time = m_time - 1;
         if (m_time == 0) begin m_phase = 2; m_done = 1; end
      end
   endtask

   // Called at posedge+1: pulses rst and realigns to posedge+1.
   task automatic do_reset();
      en = 0; func = 0; tick = 0; rst = 1;
      #2 rst = 0;
      @(posedge clk); #1;
      model_reset();
   endtask

   task automatic step(input bit e, input int f, input int ms, input bit t);
      en = e; func = 3'(f); mode_sel = 2'(ms); tick = t;
      @(posedge clk); #1;
      model_step(e, f, ms, t);
      en = 0; func = 0; tick = 0;
   endtask

   task automatic test_reset();
      #1;
      model_reset();
      checks++;
      if (game_state !== 8'h01) $display("FAIL reset_gs: got %h want 01", game_state);
      else passes++;
      checks++;
      if (time_left !== 16'd0 || running !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0)
         $display("FAIL reset_flags: got t=%0d r=%b d=%b e=%b want 0", time_left, running,
                  done, cmd_err);
      else passes++;
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_timed_round();
      int ndone;
      do_reset();
      step(1, 1, 2, 0);
      checks++;
      if (game_state !== 8'h25 || time_left !== 16'd60)
         $display("FAIL start_mode2: got gs=%h t=%0d want 25/60", game_state, time_left);
      else passes++;
      ndone = 0;
      for (int i = 0; i < 60; i++) begin
         step(0, 0, 1, 1);
         if (done === 1'b1) ndone++;
         checks++;
         if (game_state !== exp_gs() || time_left !== 16'(m_time) || done !== m_done)
            $display("FAIL round_tick%0d: got gs=%h t=%0d d=%b want %h/%0d/%b", i, game_state,
                     time_left, done, exp_gs(), m_time, m_done);
         else passes++;
      end
      checks++;
      if (ndone != 1 || game_state !== 8'h29 || time_left !== 16'd0)
         $display("FAIL round_end: got pulses=%0d gs=%h t=%0d want 1/29/0", ndone, game_state,
                  time_left);
      else passes++;
   endtask

   task automatic test_pause_resume();
      do_reset();
      step(1, 1, 0, 0);
      checks++;
      if (game_state !== 8'h05) $display("FAIL pr_start: got %h want 05", game_state);
      else passes++;
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
      step(1, 3, 3, 0);
      checks++;
      if (game_state !== 8'h0D || time_left !== 16'd55)
         $display("FAIL pr_pause: got gs=%h t=%0d want 0D/55", game_state, time_left);
      else passes++;
      for (int i = 0; i < 10; i++) step(0, 0, 3, 1);
      step(1, 4, 3, 0);
      checks++;
      if (game_state !== 8'h05 || time_left !== 16'd55 || running !== 1'b1)
         $display("FAIL pr_resume: got gs=%h t=%0d r=%b want 05/55/1", game_state, time_left,
                  running);
      else passes++;
   endtask

   task automatic test_illegal();
      do_reset();
      step(1, 4, 0, 0);
      checks++;
      if (cmd_err !== 1'b1 || game_state !== 8'h01)
         $display("FAIL ill_resume: got e=%b gs=%h want 1/01", cmd_err, game_state);
      else passes++;
      step(1, 7, 0, 0);
      checks++;
      if (cmd_err !== 1'b1 || game_state !== 8'h01)
         $display("FAIL ill_111: got e=%b gs=%h want 1/01", cmd_err, game_state);
      else passes++;
      step(0, 0, 0, 0);
      checks++;
      if (cmd_err !== 1'b0) $display("FAIL ill_pulse: got e=%b want 0", cmd_err);
      else passes++;
   endtask

   task automatic test_end_tick();
      do_reset();
      step(1, 1, 0, 0);
      for (int i = 0; i < 59; i++) step(0, 0, 0, 1);
      checks++;
      if (time_left !== 16'd1) $display("FAIL et_pre: got t=%0d want 1", time_left);
      else passes++;
      step(1, 2, 0, 1);
      checks++;
      if (game_state !== 8'h09 || time_left !== 16'd1 || done !== 1'b0)
         $display("FAIL et_end: got gs=%h t=%0d d=%b want 09/1/0", game_state, time_left, done);
      else passes++;
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1, 1, 1, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
      #3 rst = 1;
      #1;
      checks++;
      if (game_state !== 8'h01 || time_left !== 16'd0 || running !== 1'b0)
         $display("FAIL async_rst: got gs=%h t=%0d r=%b want 01/0/0", game_state, time_left,
                  running);
      else passes++;
      #2 rst = 0;
      @(posedge clk); #1;
      model_reset();
   endtask

   task automatic test_random();
      int f, r, nz;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         nz = (i < 1500) ? 3 : 63;
         r = int'($urandom_range(nz, 0));
         f = (r == 0) ? int'($urandom_range(7, 0)) : 0;
         step(($urandom_range(9, 0) < 8), f, int'($urandom_range(3, 0)), $urandom_range(1, 0) == 1);
         checks++;
         if (game_state !== exp_gs() || time_left !== 16'(m_time) || done !== m_done ||
             cmd_err !== m_err || running !== (m_phase == 1))
            $display("FAIL rand%0d: got gs=%h t=%0d d=%b e=%b r=%b want %h/%0d/%b/%b/%b", i,
                     game_state, time_left, done, cmd_err, running, exp_gs(), m_time, m_done,
                     m_err, m_phase == 1);
         else passes++;
      end
   endtask

   task automatic test_untimed();
      int ndone;
      do_reset();
      en0 = 1; func0 = 3'd1; mode_sel0 = 2'd0;
      @(posedge clk); #1;
      en0 = 0; func0 = 0;
      ndone = 0;
      for (int i = 0; i < 1000; i++) begin
         tick0 = 1;
         @(posedge clk); #1;
         if (done0 === 1'b1) ndone++;
      end
      tick0 = 0;
      checks++;
      if (running0 !== 1'b1 || time_left0 !== 16'd0 || ndone != 0 || game_state0 !== 8'h05)
         $display("FAIL untimed: got r=%b t=%0d pulses=%0d gs=%h want 1/0/0/05", running0,
                  time_left0, ndone, game_state0);
      else passes++;
      en0 = 0; func0 = 3'd2;
      @(posedge clk); #1;
      func0 = 0;
      checks++;
      if (game_state0 !== 8'h05 || cmd_err0 !== 1'b0)
         $display("FAIL en0_end: got gs=%h e=%b want 05/0", game_state0, cmd_err0);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_timed_round();
      test_pause_resume();
      test_illegal();
      test_end_tick();
      test_async_reset();
      test_random();
      test_untimed();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
